// File: rtl/serial_pkg.sv
// Shared serial-transmitter definitions: UART TX state encoding, frame constants
// and the default baud divisor.
package serial_pkg;

  typedef logic [2:0] uart_tx_state_t;

  localparam uart_tx_state_t ST_IDLE   = 3'd0;
  localparam uart_tx_state_t ST_START  = 3'd1;
  localparam uart_tx_state_t ST_DATA   = 3'd2;
  localparam uart_tx_state_t ST_PARITY = 3'd3;
  localparam uart_tx_state_t ST_STOP   = 3'd4;

  localparam int   UART_DATA_BITS            = 8;
  localparam logic UART_IDLE_LEVEL           = 1'b1;
  localparam int   UART_CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/uart_tx_engine_if.sv
// Byte handshake between the serial byte sequencer (master) and the UART TX engine (slave).
interface uart_tx_engine_if;
  import serial_pkg::*;

  logic                      new_tx_data;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_busy;
  logic                      tx;

  modport master (output new_tx_data, output tx_data, input tx_busy, input tx);
  modport slave  (input new_tx_data, input tx_data, output tx_busy, output tx);
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  output logic bit_done_o
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_done_o = (cnt == LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                    cnt <= '0;
    else if (clear_i || bit_done_o)  cnt <= '0;
    else                             cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter, one byte per handshake. Define UART_TX_PARITY_EN to insert
// an even-parity bit between the data bits and the stop bit (8E1).
module uart_tx_engine
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input logic             clk_i,
  input logic             rst_n_i,
  uart_tx_engine_if.slave tx_if
);
  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state, state_nxt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [2:0]                bit_idx;
  logic                      bit_done, accept, clear;
  logic                      tx_q, busy_q;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q;
`endif

  // Busy is registered and low only in IDLE, so IDLE alone qualifies a request.
  assign accept = (state == ST_IDLE) && tx_if.new_tx_data;
  // Hold the timer at zero while idle and restart it on every state change.
  assign clear  = (state == ST_IDLE) || (state_nxt != state);

  assign tx_if.tx      = tx_q;
  assign tx_if.tx_busy = busy_q;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (clear),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)   state_nxt = ST_START;
      ST_START: if (bit_done) state_nxt = ST_DATA;
`ifdef UART_TX_PARITY_EN
      ST_DATA:   if (bit_done && bit_idx == LAST_IDX) state_nxt = ST_PARITY;
      ST_PARITY: if (bit_done) state_nxt = ST_STOP;
`else
      ST_DATA:   if (bit_done && bit_idx == LAST_IDX) state_nxt = ST_STOP;
`endif
      ST_STOP:  if (bit_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // tx_q is loaded with the level of the upcoming bit at each bit boundary.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      tx_q     <= UART_IDLE_LEVEL;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (accept) begin
          shreg    <= tx_if.tx_data;
          bit_idx  <= '0;
          tx_q     <= ~UART_IDLE_LEVEL;
          busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_q <= ^tx_if.tx_data;
`endif
        end
        ST_START: if (bit_done) tx_q <= shreg[0];
        ST_DATA: if (bit_done) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
          tx_q    <= (bit_idx == LAST_IDX) ? parity_q : shreg[1];
`else
          tx_q    <= (bit_idx == LAST_IDX) ? UART_IDLE_LEVEL : shreg[1];
`endif
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: if (bit_done) tx_q <= UART_IDLE_LEVEL;
`endif
        ST_STOP: if (bit_done) begin
          tx_q   <= UART_IDLE_LEVEL;
          busy_q <= 1'b0;
        end
        default: begin
          tx_q   <= UART_IDLE_LEVEL;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
